// File: rtl/wfg_pat_pkg.sv
// Shared types and widths for the pattern-driver timing path.
package wfg_pat_pkg;

  localparam int SUBCYCLE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pat_timer_state_e;

endpackage

// File: rtl/wfg_pat_timer_div.sv
// Reusable divider: counts enabled clocks and ticks when the count hits the load value.
module wfg_pat_timer_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] load,
  output logic [W-1:0] cnt,
  output logic         tick
);

  assign tick = en && (cnt == load);

  // Equality wrap only, so an all-ones load value is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wfg_pat_timer.sv
// Pattern timer: splits clk into subcycles and cycles, emitting sync/subcycle pulses.
// Optional burst mode (stop after N cycles) is enabled by defining WFG_PAT_TIMER_BURST_EN.
module wfg_pat_timer
  import wfg_pat_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctrl_en_q_i,
  input  logic [DIV_WIDTH-1:0]   cfg_clkdiv_q_i,
  input  logic [SUBCYCLE_W-1:0]  cfg_subcycles_q_i,
  input  logic [BURST_WIDTH-1:0] cfg_burst_q_i,
  output logic                   pat_sync_o,
  output logic                   pat_subcycle_o,
  output logic [SUBCYCLE_W-1:0]  pat_subcycle_cnt_o,
  output logic                   active_o,
  output logic                   burst_done_o
);

  pat_timer_state_e      state;
  logic [DIV_WIDTH-1:0]  clkdiv_sh;
  logic [SUBCYCLE_W-1:0] subcycles_sh;
  logic [DIV_WIDTH-1:0]  div_cnt_unused;
  logic [SUBCYCLE_W-1:0] sub_cnt;
  logic                  run;
  logic                  start;
  logic                  div_tick;
  logic                  cycle_end;
  logic                  burst_hit;

  // Counters only advance in RUN with enable held; anything else clears them.
  assign run   = (state == RUN) && ctrl_en_q_i;
  assign start = (state == IDLE) && ctrl_en_q_i;

  wfg_pat_timer_div #(.W(DIV_WIDTH)) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!run),
    .en   (run),
    .load (clkdiv_sh),
    .cnt  (div_cnt_unused),
    .tick (div_tick)
  );

  wfg_pat_timer_div #(.W(SUBCYCLE_W)) u_sub_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!run),
    .en   (div_tick),
    .load (subcycles_sh),
    .cnt  (sub_cnt),
    .tick (cycle_end)
  );

  // sub_cnt is a flop that is held at 0 outside RUN, so it drives the index output directly.
  assign pat_subcycle_cnt_o = sub_cnt;

`ifdef WFG_PAT_TIMER_BURST_EN
  logic [BURST_WIDTH-1:0] burst_sh;
  logic [BURST_WIDTH-1:0] burst_cnt;

  assign burst_hit = run && cycle_end && (burst_sh != '0) && (burst_cnt == burst_sh);

  // burst_cnt holds the number of syncs emitted so far in this burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_sh  <= '0;
      burst_cnt <= '0;
    end else if (start) begin
      burst_sh  <= cfg_burst_q_i;
      burst_cnt <= BURST_WIDTH'(1);
    end else if (run && cycle_end && !burst_hit) begin
      burst_sh  <= cfg_burst_q_i;
      burst_cnt <= burst_cnt + BURST_WIDTH'(1);
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^cfg_burst_q_i;
  assign burst_hit    = 1'b0;
`endif

  // Control FSM; all outputs are registered here and go to 0 whenever enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      clkdiv_sh      <= '0;
      subcycles_sh   <= '0;
      pat_sync_o     <= 1'b0;
      pat_subcycle_o <= 1'b0;
      active_o       <= 1'b0;
      burst_done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pat_sync_o     <= ctrl_en_q_i;
          pat_subcycle_o <= ctrl_en_q_i;
          active_o       <= ctrl_en_q_i;
          burst_done_o   <= 1'b0;
          if (ctrl_en_q_i) begin
            state        <= RUN;
            clkdiv_sh    <= cfg_clkdiv_q_i;
            subcycles_sh <= cfg_subcycles_q_i;
          end
        end
        RUN: begin
          if (!ctrl_en_q_i) begin
            state          <= IDLE;
            pat_sync_o     <= 1'b0;
            pat_subcycle_o <= 1'b0;
            active_o       <= 1'b0;
          end else if (burst_hit) begin
            state          <= DONE;
            pat_sync_o     <= 1'b0;
            pat_subcycle_o <= 1'b0;
            active_o       <= 1'b0;
            burst_done_o   <= 1'b1;
          end else begin
            pat_subcycle_o <= div_tick;
            pat_sync_o     <= cycle_end;
            if (cycle_end) begin
              clkdiv_sh    <= cfg_clkdiv_q_i;
              subcycles_sh <= cfg_subcycles_q_i;
            end
          end
        end
        DONE: begin
          pat_sync_o     <= 1'b0;
          pat_subcycle_o <= 1'b0;
          active_o       <= 1'b0;
          if (!ctrl_en_q_i) begin
            state        <= IDLE;
            burst_done_o <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          pat_sync_o     <= 1'b0;
          pat_subcycle_o <= 1'b0;
          active_o       <= 1'b0;
          burst_done_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wfg_pat_timer.sv
// Self-checking bench for wfg_pat_timer: cycle-position model plus directed literal checks.
module tb_wfg_pat_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en = 1'b0;
  logic [15:0] cd = 16'd3;
  logic [7:0]  sc = 8'd4;
  logic [15:0] bu = 16'd0;
  logic        pat_sync, pat_sub, active, done;
  logic [7:0]  cnt;
  logic [11:0] outs;

  int n_pass  = 0;
  int n_total = 0;
  int nsync;

`ifdef WFG_PAT_TIMER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  wfg_pat_timer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_en_q_i       (en),
    .cfg_clkdiv_q_i    (cd),
    .cfg_subcycles_q_i (sc),
    .cfg_burst_q_i     (bu),
    .pat_sync_o        (pat_sync),
    .pat_subcycle_o    (pat_sub),
    .pat_subcycle_cnt_o(cnt),
    .active_o          (active),
    .burst_done_o      (done)
  );

  assign outs = {pat_sync, pat_sub, cnt, active, done};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: position p within the current cycle, with the cycle's config latched at its start.
  bit m_active = 1'b0, m_done = 1'b0;
  int m_p = 0, m_cd = 0, m_sc = 0, m_bsh = 0, m_syncs = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_p = 0;
    end else if (!en) begin
      m_active = 1'b0; m_done = 1'b0; m_p = 0;
    end else if (m_done) begin
      m_p = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_p = 0; m_syncs = 1;
      m_cd = int'(cd); m_sc = int'(sc); m_bsh = int'(bu);
    end else begin
      m_p++;
      if (m_p == (m_cd + 1) * (m_sc + 1)) begin
        m_p = 0;
        if (BURST && m_bsh != 0 && m_syncs == m_bsh) begin
          m_active = 1'b0; m_done = 1'b1;
        end else begin
          m_syncs++;
          m_cd = int'(cd); m_sc = int'(sc); m_bsh = int'(bu);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    logic [11:0] exp;
    @(negedge clk);
    exp = {m_active && (m_p == 0),
           m_active && (m_p % (m_cd + 1) == 0),
           m_active ? 8'(m_p / (m_cd + 1)) : 8'd0,
           m_active, m_done};
    chk("model", 32'(outs), 32'(exp));
  end

  initial begin
    rst_n = 1'b0;
    tick(2);
    chk("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // clkdiv=3, subcycles=4: period 20, subcycle every 4
    en = 1'b1;
    tick(1);
    chk("first_sync", 32'({pat_sync, pat_sub, cnt, active}), 32'({1'b1, 1'b1, 8'd0, 1'b1}));
    tick(4);
    chk("sub1", 32'({pat_sync, pat_sub, cnt}), 32'({1'b0, 1'b1, 8'd1}));
    tick(16);
    chk("period20", 32'({pat_sync, cnt}), 32'({1'b1, 8'd0}));

    // subcycles 4->1 mid-cycle: current cycle still reaches cnt 4
    tick(6);
    sc = 8'd1;
    tick(10);
    chk("old_cycle_cnt4", 32'(cnt), 32'd4);
    tick(4);
    chk("new_cfg_sync", 32'(pat_sync), 32'd1);
    tick(4);
    chk("new_cfg_cnt1", 32'({pat_sub, cnt}), 32'({1'b1, 8'd1}));
    tick(4);
    chk("period8", 32'({pat_sync, cnt}), 32'({1'b1, 8'd0}));

    // back to subcycles=4, then disable at cnt=2 mid-subcycle
    sc = 8'd4;
    tick(8);
    chk("period8_again", 32'(pat_sync), 32'd1);
    tick(9);
    chk("cnt2_mid", 32'({pat_sub, cnt}), 32'({1'b0, 8'd2}));
    en = 1'b0;
    tick(1);
    chk("disable_idle", 32'(outs), 32'd0);
    en = 1'b1;
    tick(1);
    chk("reenable_sync", 32'({pat_sync, pat_sub, cnt, active}), 32'({1'b1, 1'b1, 8'd0, 1'b1}));

    // clkdiv=0, subcycles=0: everything high continuously
    en = 1'b0;
    tick(1);
    cd = 16'd0; sc = 8'd0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("div0_sub0", 32'({pat_sync, pat_sub, active, cnt}), 32'({1'b1, 1'b1, 1'b1, 8'd0}));
    end

    // clkdiv all ones is legal: one long subcycle
    en = 1'b0;
    tick(1);
    cd = 16'hFFFF; sc = 8'd0; en = 1'b1;
    tick(1);
    chk("divmax_sync", 32'({pat_sync, pat_sub}), 32'({1'b1, 1'b1}));
    tick(30);
    chk("divmax_hold", 32'({pat_sync, pat_sub, active, cnt}), 32'({1'b0, 1'b0, 1'b1, 8'd0}));

    // burst=3 with period 4
    en = 1'b0;
    tick(1);
    cd = 16'd1; sc = 8'd1; bu = 16'd3; en = 1'b1;
    nsync = 0;
    repeat (30) begin
      tick(1);
      nsync += int'(pat_sync);
    end
    if (BURST) begin
      chk("burst_syncs", 32'(nsync), 32'd3);
      chk("burst_done", 32'({done, active}), 32'({1'b1, 1'b0}));
    end else begin
      chk("cont_syncs", 32'(nsync), 32'd8);
      chk("cont_active", 32'({done, active}), 32'({1'b0, 1'b1}));
    end
    en = 1'b0;
    tick(1);
    chk("done_clear", 32'({done, active}), 32'd0);

    // async reset mid-RUN, release with enable high
    bu = 16'd0; cd = 16'd3; sc = 8'd4; en = 1'b1;
    tick(7);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(outs), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_reset_sync", 32'({pat_sync, cnt, active}), 32'({1'b1, 8'd0, 1'b1}));
    tick(25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wfg_pat_timer.md
# wfg_pat_timer

Timing generator for the pattern driver path. It divides `clk` into subcycles and groups subcycles into pattern cycles. Each cycle it emits a one-clock `pat_sync_o` pulse and a running subcycle index. These feed the pattern driver's `pat_sync_i` and `pat_subcycle_cnt_i`, which fetch one AXI-stream word per cycle and gate outputs by subcycle window.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the clock-divider counter and its config.
- `BURST_WIDTH`, default 16: width of the burst cycle counter and its config.

Ports:
- `clk` in, 1: system clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `ctrl_en_q_i` in, 1: timer enable, level.
- `cfg_clkdiv_q_i` in, DIV_WIDTH: clocks per subcycle minus 1.
- `cfg_subcycles_q_i` in, 8: subcycles per cycle minus 1.
- `cfg_burst_q_i` in, BURST_WIDTH: cycles per burst; 0 = continuous. Used only with the macro.
- `pat_sync_o` out, 1: one-clock pulse on the first clock of every cycle.
- `pat_subcycle_o` out, 1: one-clock pulse on the first clock of every subcycle.
- `pat_subcycle_cnt_o` out, 8: current subcycle index.
- `active_o` out, 1: high while in RUN.
- `burst_done_o` out, 1: burst completed. Tied 0 without the macro.

## Operation
- FSM states: IDLE, RUN, DONE. DONE is reachable only with the macro.
- All outputs are registered. Reset value of every output is 0. Reset places the FSM in IDLE with all counters at 0.
- IDLE -> RUN on the first edge with `ctrl_en_q_i`=1. On that edge:
  - `div_cnt` <= 0, `sub_cnt` <= 0.
  - `pat_sync_o` <= 1, `pat_subcycle_o` <= 1.
  - Config shadow registers load `cfg_clkdiv_q_i`, `cfg_subcycles_q_i` and `cfg_burst_q_i`.
- In RUN, on each edge:
  - If `div_cnt` != `clkdiv_sh`: `div_cnt`++ and both pulses go to 0.
  - Else `div_cnt` <= 0 and `pat_subcycle_o` <= 1. Then:
    - If `sub_cnt` != `subcycles_sh`: `sub_cnt`++.
    - Else `sub_cnt` <= 0 and `pat_sync_o` <= 1. This is a cycle boundary: the shadows reload from the cfg inputs.
- Config changes take effect only at a cycle boundary, never mid-cycle.
- `pat_subcycle_cnt_o` = `sub_cnt`. It is valid while `active_o`=1 and forced to 0 in IDLE and DONE.
- Cycle period = (clkdiv+1)*(subcycles+1) clocks.
  - clkdiv=0: `pat_subcycle_o` is high every clock.
  - clkdiv=0 and subcycles=0: `pat_sync_o` is high continuously.
- Counters compare with equality only; there is no overflow path. clkdiv at its maximum (all ones) is legal.
- `ctrl_en_q_i`=0 in any state: next edge goes to IDLE, counters clear, all outputs go to 0. A pulse in flight is cut off.
- Re-enable always restarts at subcycle 0 with a fresh sync.

## Timing
- Enable-to-first-sync latency: 1 clock. `ctrl_en_q_i` is sampled at edge N; `pat_sync_o` is high during cycle N+1.
- `pat_sync_o` and `pat_subcycle_o` assert together at a cycle start. `pat_subcycle_cnt_o` reads 0 in that same clock.
- A cfg change is visible on the first cycle boundary after it.
- Disable-to-idle latency: 1 clock.

## Configuration
Macro: `WFG_PAT_TIMER_BURST_EN`.

With the macro defined:
- `burst_cnt` counts emitted syncs.
- If `burst_sh` != 0 and a cycle boundary is reached with `burst_cnt` == `burst_sh`: go to DONE instead of emitting a sync.
- In DONE: `burst_done_o`=1, `active_o`=0, pulses are 0.
- DONE holds until `ctrl_en_q_i`=0, then goes to IDLE and `burst_done_o` clears.

Without the macro:
- Continuous operation only.
- `cfg_burst_q_i` is ignored and `burst_done_o` is tied 0.

## Structure
- Shared package `wfg_pat_pkg`, containing:
  - The `pat_timer_state_e` enum (IDLE, RUN, DONE).
  - `SUBCYCLE_W`=8.
- Natural sub-module: `wfg_pat_timer_div`. It is a reusable divider that emits a tick when the count hits the load value. Instance 1 is the clock divider. Instance 2 counts subcycles and is enabled by instance 1's tick.

## Test plan
- clkdiv=3, subcycles=4, enable: first sync 1 clk after enable; sync period 20 clks; subcycle pulse every 4 clks; cnt sequence 0,1,2,3,4,0.
- clkdiv=0, subcycles=0: `pat_sync_o`, `pat_subcycle_o` and `active_o` all stay high; cnt stays 0.
- Change subcycles 4->1 mid-cycle: current cycle finishes with cnt up to 4; the next cycle has period (clkdiv+1)*2.
- Deassert enable at cnt=2 mid-subcycle: next clock all outputs 0. Re-enable gives sync 1 clk later with cnt=0.
- With the macro, burst=3: exactly 3 syncs, then `burst_done_o`=1 and `active_o`=0. `burst_done_o` clears 1 clk after enable drops.
- Assert `rst_n`=0 mid-RUN: outputs 0 immediately (async). After release with enable high, sync 1 clk after the first edge.
